// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter feeding one 8N1-style serial transmitter.
// Requesters offer bytes with a valid/ready handshake. The arbiter grants one of
// them only while the line is idle, and the transmitter then shifts the latched
// byte out LSB first between a low start bit and a high stop bit.
`timescale 1ns/1ps

module uart_tx_arbiter #(
  parameter int DIVISOR    = 10000,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          data_out,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          frame_done
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CW-1:0] CNT_MAX   = CW'(DIVISOR - 1);
  localparam logic [BW-1:0] BIT_MAX   = BW'(DATA_WIDTH - 1);
  localparam logic [GW-1:0] LAST_INIT = GW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_SEND  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t                  state, state_next;
  logic [CW-1:0]           cnt, cnt_next;
  logic [BW-1:0]           bit_idx, bit_next;
  logic [DATA_WIDTH-1:0]   shreg, shreg_next;
  logic                    data_next;
  logic [GW-1:0]           grant_next;
  logic [GW-1:0]           last_grant, last_next;
  logic                    done_next;

  logic                    found;
  logic [GW-1:0]           winner;
  logic [GW-1:0]           cand_idx;
  int                      cand;
  logic                    transfer;

  logic [DATA_WIDTH-1:0]   req_bytes [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_bytes[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin search: first valid requester starting just after the last winner.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_grant) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = GW'(cand);
      if (!found && req_valid[cand_idx]) begin
        found  = 1'b1;
        winner = cand_idx;
      end
    end
  end

  // Ready is offered only on idle cycles and is held low while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (found && (state == S_IDLE) && !rst_in) begin
      req_ready[winner] = 1'b1;
    end
  end

  assign transfer = |(req_valid & req_ready);
  assign busy     = (state != S_IDLE);

  // Next-state and datapath decode for the start/data/stop bit sequence.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    bit_next   = bit_idx;
    shreg_next = shreg;
    data_next  = data_out;
    grant_next = grant_id;
    last_next  = last_grant;
    done_next  = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_next  = '0;
        bit_next  = '0;
        data_next = 1'b1;
        if (transfer) begin
          state_next = S_START;
          shreg_next = req_bytes[winner];
          grant_next = winner;
          last_next  = winner;
          data_next  = 1'b0;
        end
      end
      S_START: begin
        if (cnt == CNT_MAX) begin
          cnt_next   = '0;
          bit_next   = '0;
          state_next = S_SEND;
          data_next  = shreg[0];
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      S_SEND: begin
        if (cnt == CNT_MAX) begin
          cnt_next = '0;
          if (bit_idx == BIT_MAX) begin
            state_next = S_STOP;
            data_next  = 1'b1;
          end else begin
            bit_next   = bit_idx + 1'b1;
            shreg_next = shreg >> 1;
            data_next  = shreg[1];
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt == CNT_MAX) begin
          cnt_next   = '0;
          state_next = S_IDLE;
          data_next  = 1'b1;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
        bit_next   = '0;
        data_next  = 1'b1;
      end
    endcase
  end

  // State register; reset parks the machine idle immediately.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath registers; reset drops any byte in flight and drives the line high.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      data_out   <= 1'b1;
      grant_id   <= '0;
      last_grant <= LAST_INIT;
      frame_done <= 1'b0;
    end else begin
      cnt        <= cnt_next;
      bit_idx    <= bit_next;
      shreg      <= shreg_next;
      data_out   <= data_next;
      grant_id   <= grant_next;
      last_grant <= last_next;
      frame_done <= done_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench for uart_tx_arbiter with DIVISOR=4,
// DATA_WIDTH=8, NUM_REQ=4. Expected line values are computed from the byte
// each requester offered at its grant.
`timescale 1ns/1ps

module tb_uart_tx_arbiter;

  localparam int DIVISOR    = 4;
  localparam int DATA_WIDTH = 8;
  localparam int NUM_REQ    = 4;
  localparam int FRAME_LEN  = 10 * DIVISOR;

  logic                          clk_in = 1'b0;
  logic                          rst_in;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          data_out;
  logic                          busy;
  logic [1:0]                    grant_id;
  logic                          frame_done;

  int compared   = 0;
  int mismatched = 0;

  uart_tx_arbiter #(
    .DIVISOR   (DIVISOR),
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_REQ   (NUM_REQ)
  ) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .data_out  (data_out),
    .busy      (busy),
    .grant_id  (grant_id),
    .frame_done(frame_done)
  );

  // 10 ns clock
  always #5 clk_in = ~clk_in;

  // Safety net so a stuck design cannot hang the run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] valid, input logic [31:0] data);
    req_valid = valid;
    req_data  = data;
  endtask

  // Reset pulse spanning one rising edge, released on a falling edge
  task automatic resetPulse();
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  // Wait (bounded) until some req_ready bit is offered; sits 1 ns after a falling edge
  task automatic waitReady(input int budget, output int waited);
    waited = 0;
    #1;
    while ((req_ready == '0) && (waited < budget)) begin
      @(negedge clk_in);
      #1;
      waited++;
    end
    checkOutput("ready_timeout", 32'(req_ready != '0), 32'd1);
  endtask

  // Called on the falling edge right after the transfer edge; walks the whole
  // frame and ends on the falling edge of the first idle cycle.
  task automatic checkFrame(input logic [7:0] data, input logic [1:0] exp_grant, input bit churn);
    int   slot;
    logic exp_bit;
    for (int n = 0; n < FRAME_LEN; n++) begin
      slot = n / DIVISOR;
      if (slot == 0) begin
        exp_bit = 1'b0;
      end else if (slot == 9) begin
        exp_bit = 1'b1;
      end else begin
        exp_bit = data[3'(slot - 1)];
      end
      checkOutput($sformatf("line_n%0d", n), 32'(data_out), 32'(exp_bit));
      checkOutput($sformatf("busy_n%0d", n), 32'(busy), 32'd1);
      checkOutput($sformatf("done_n%0d", n), 32'(frame_done), 32'd0);
      checkOutput($sformatf("ready_n%0d", n), 32'(req_ready), 32'd0);
      checkOutput($sformatf("grant_n%0d", n), 32'(grant_id), 32'(exp_grant));
      if (churn && n == 10) applyStimulus(4'b1111, 32'h0000_0000);
      if (churn && n == 20) applyStimulus(4'b0000, 32'hFFFF_FFFF);
      if (churn && n == 30) applyStimulus(4'b0110, 32'h1234_5678);
      @(negedge clk_in);
    end
    checkOutput("end_done", 32'(frame_done), 32'd1);
    checkOutput("end_busy", 32'(busy), 32'd0);
    checkOutput("end_line", 32'(data_out), 32'd1);
    checkOutput("end_grant", 32'(grant_id), 32'(exp_grant));
  endtask

  logic [7:0] rr_bytes [4] = '{8'hA5, 8'h3C, 8'h0F, 8'hF0};

  initial begin
    int waited;

    // Reset with everyone asking: nothing granted, line high, before any edge
    rst_in = 1'b1;
    applyStimulus(4'b1111, 32'hFFFF_FFFF);
    #3;
    checkOutput("rst_line", 32'(data_out), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_grant", 32'(grant_id), 32'd0);
    checkOutput("rst_done", 32'(frame_done), 32'd0);

    // Single byte 0x55 from requester 0
    @(negedge clk_in);
    rst_in = 1'b0;
    applyStimulus(4'b0001, 32'h0000_0055);
    #1;
    checkOutput("single_ready", 32'(req_ready), 32'b0001);
    @(negedge clk_in);
    applyStimulus(4'b0000, 32'h0000_0000);
    checkFrame(8'h55, 2'd0, 1'b0);
    #1;
    checkOutput("single_no_refire", 32'(req_ready), 32'd0);

    // Round robin with all four valid after reset: 0,1,2,3,0 with minimal gaps
    @(negedge clk_in);
    applyStimulus(4'b1111, 32'hF00F_3CA5);
    resetPulse();
    for (int g = 0; g < 5; g++) begin
      waitReady(60, waited);
      checkOutput($sformatf("rr_ready_%0d", g), 32'(req_ready), 32'(1 << (g % 4)));
      if (g > 0) checkOutput($sformatf("rr_gap_%0d", g), 32'(waited), 32'd0);
      @(negedge clk_in);
      checkFrame(rr_bytes[g % 4], 2'(g % 4), 1'b0);
    end
    applyStimulus(4'b0000, 32'h0000_0000);

    // Contention skip: make requester 1 the last winner, then offer 3 and 0
    applyStimulus(4'b0010, 32'h0000_9600);
    waitReady(10, waited);
    checkOutput("skip_setup_ready", 32'(req_ready), 32'b0010);
    @(negedge clk_in);
    applyStimulus(4'b1001, 32'h8100_007E);
    checkFrame(8'h96, 2'd1, 1'b0);
    #1;
    checkOutput("skip_ready_3", 32'(req_ready), 32'b1000);
    @(negedge clk_in);
    checkFrame(8'h81, 2'd3, 1'b0);
    #1;
    checkOutput("skip_ready_0", 32'(req_ready), 32'b0001);
    applyStimulus(4'b0000, 32'h0000_0000);

    // Mid-frame churn on valid/data must not disturb the latched byte
    applyStimulus(4'b0001, 32'h0000_00C3);
    waitReady(10, waited);
    checkOutput("churn_ready", 32'(req_ready), 32'b0001);
    @(negedge clk_in);
    checkFrame(8'hC3, 2'd0, 1'b1);
    #1;
    checkOutput("churn_after_ready", 32'(req_ready), 32'b0010);
    applyStimulus(4'b0000, 32'h0000_0000);

    // Async reset at clock 17 of a frame from requester 2 (byte 0xF0, bit3 = 0)
    applyStimulus(4'b0100, 32'h00F0_0000);
    waitReady(10, waited);
    checkOutput("abort_setup_ready", 32'(req_ready), 32'b0100);
    @(negedge clk_in);
    applyStimulus(4'b1111, 32'h4433_2211);
    for (int i = 0; i < 17; i++) @(negedge clk_in);
    checkOutput("abort_pre_line", 32'(data_out), 32'd0);
    checkOutput("abort_pre_grant", 32'(grant_id), 32'd2);
    #2;
    rst_in = 1'b1;
    #1;
    checkOutput("abort_line", 32'(data_out), 32'd1);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_ready", 32'(req_ready), 32'd0);
    checkOutput("abort_grant", 32'(grant_id), 32'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    checkOutput("fresh_ready", 32'(req_ready), 32'b0001);
    @(negedge clk_in);
    checkFrame(8'h11, 2'd0, 1'b0);
    applyStimulus(4'b0000, 32'h0000_0000);

    // Idle for 100 clocks: line high, nothing busy, nothing offered
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_in);
      checkOutput($sformatf("idle_line_%0d", i), 32'(data_out), 32'd1);
      checkOutput($sformatf("idle_busy_%0d", i), 32'(busy), 32'd0);
      checkOutput($sformatf("idle_ready_%0d", i), 32'(req_ready), 32'd0);
      checkOutput($sformatf("idle_done_%0d", i), 32'(frame_done), 32'd0);
    end
    checkOutput("idle_grant_hold", 32'(grant_id), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
